aes_128_core: RTL and testbench

AES_128_CORE -- requirements
Module: aes_128

---
 rtl/aes_128_core.sv | 147 ++++++++++++++
 tb/tb_aes_128_core.sv | 97 +++++++++
 2 files changed

// File: rtl/aes_128_core.sv
// AES-128 encryption, fully pipelined: one block per clock, 20-cycle latency from sampling edge to out.
// Each round is split into SubBytes/ShiftRows/KeyExpand and MixColumns/AddRoundKey register stages.
module aes_128_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out
);

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    gf_mul = p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] b;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    b = r;
    sbox = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(d[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    sub_shift = o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] d);
    logic [127:0] o;
    logic [7:0]   s0, s1, s2, s3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      s0 = d[127-32*c -: 8];
      s1 = d[119-32*c -: 8];
      s2 = d[111-32*c -: 8];
      s3 = d[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
      o[119-32*c -: 8] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
      o[111-32*c -: 8] = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
      o[103-32*c -: 8] = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
    end
    mix = o;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    key_exp = {n0, n1, n2, n3};
  endfunction

  logic [127:0] r_in_dat;
  logic [127:0] r_in_key;
  logic         r_in_vld;
  logic [18:0]  r_vld;
  logic [127:0] r_a_dat [10];
  logic [127:0] r_a_key [10];
  logic [127:0] r_b_dat [9];
  logic [127:0] r_b_key [9];
  logic [127:0] r_out;

  logic [127:0] w_a_dat [10];
  logic [127:0] w_a_key [10];
  logic [127:0] w_b_dat [9];

  always_comb begin
    w_a_dat = '{default: '0};
    w_a_key = '{default: '0};
    w_b_dat = '{default: '0};
    w_a_dat[0] = sub_shift(r_in_dat);
    w_a_key[0] = key_exp(r_in_key, RCON[0]);
    for (int i = 1; i < 10; i++) begin
      w_a_dat[i] = sub_shift(r_b_dat[i-1]);
      w_a_key[i] = key_exp(r_b_key[i-1], RCON[i]);
    end
    for (int i = 0; i < 9; i++) begin
      w_b_dat[i] = mix(r_a_dat[i]) ^ r_a_key[i];
    end
  end

  // r_vld[k] travels with stage k+1; only the out register is gated by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_dat <= '0;
      r_in_key <= '0;
      r_in_vld <= 1'b0;
      r_vld    <= '0;
      r_out    <= '0;
      for (int i = 0; i < 10; i++) begin
        r_a_dat[i] <= '0;
        r_a_key[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        r_b_dat[i] <= '0;
        r_b_key[i] <= '0;
      end
    end else begin
      r_in_dat <= state ^ key;
      r_in_key <= key;
      r_in_vld <= 1'b1;
      r_vld    <= {r_vld[17:0], r_in_vld};
      for (int i = 0; i < 10; i++) begin
        r_a_dat[i] <= w_a_dat[i];
        r_a_key[i] <= w_a_key[i];
      end
      for (int i = 0; i < 9; i++) begin
        r_b_dat[i] <= w_b_dat[i];
        r_b_key[i] <= r_a_key[i];
      end
      r_out <= r_vld[18] ? (r_a_dat[9] ^ r_a_key[9]) : '0;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_aes_128_core.sv
// Directed bench for aes_128_core: reset state, fill period, five-vector stream and mid-stream reset flush.
module tb_aes_128_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] dut_out;

  int tests = 0;
  int fails = 0;

  logic [127:0] vs [5];
  logic [127:0] vk [5];
  logic [127:0] ve [5];

  aes_128_core dut (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .key   (key),
    .out   (dut_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] exp);
    tests++;
    assert (dut_out === exp) else begin
      fails++;
      $error("FAIL %s: out=%h expected %h", tag, dut_out, exp);
    end
  endtask

  // Inputs wiggle between edges and settle just before the sampling edge.
  task automatic tick(input logic [127:0] s, input logic [127:0] k);
    state = {$urandom, $urandom, $urandom, $urandom};
    key   = {$urandom, $urandom, $urandom, $urandom};
    #1;
    state = s;
    key   = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vs[0] = 128'h3243f6a8885a308d313198a2e0370734;
    vk[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ve[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    vs[1] = 128'h00112233445566778899aabbccddeeff;
    vk[1] = 128'h000102030405060708090a0b0c0d0e0f;
    ve[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vs[2] = 128'h0;
    vk[2] = 128'h0;
    ve[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vs[3] = 128'h0;
    vk[3] = 128'h1;
    ve[3] = 128'h0545aad56da2a97c3663d1432a3d1c84;
    vs[4] = 128'h1;
    vk[4] = 128'h0;
    ve[4] = 128'h58e2fccefa7e3061367f1d57a4e7455a;

    rst   = 1'b1;
    state = '0;
    key   = '0;
    tick(vs[0], vk[0]);
    check("reset_out_0", 128'h0);
    tick(vs[1], vk[1]);
    check("reset_out_1", 128'h0);

    // Stream: E1..E5 carry the vectors, E21..E25 return them in order.
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) tick(vs[i], vk[i]);
      else       tick({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      if (i + 1 <= 20) check($sformatf("fill_zero_e%0d", i + 1), 128'h0);
      else             check($sformatf("stream_v%0d", i - 20), ve[i - 20]);
    end

    for (int i = 0; i < 10; i++) tick(vs[i % 5], vk[i % 5]);

    // Flush with a full pipeline; nothing in flight may surface afterwards.
    rst = 1'b1;
    tick(vs[0], vk[0]);
    check("flush_edge", 128'h0);
    rst = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      tick(vs[j % 5], vk[j % 5]);
      if (j <= 20) check($sformatf("flush_zero_r%0d", j), 128'h0);
      else         check($sformatf("post_flush_v%0d", (j - 20) % 5), ve[(j - 20) % 5]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
